// File: rtl/zcu104_areset_gen.sv
// zcu104_areset_gen
//
// This block generates the system reset for the ZCU104 board. It holds `areset`
// high until all of these hold:
//   - the MMCM has been locked for LOCK_STABLE_CYCLES cycles,
//   - the push-button is released (debounced),
//   - optionally, DDR calibration has completed.
// After release, losing lock or pressing the button puts the block back in
// WAIT_LOCK and raises `areset` again.
//
// Optional feature, macro DDR_CALIB_GATE_EN:
//   - defined:   STABLE -> WAIT_CALIB -> RUN, with ddr_calib_done gating release.
//   - undefined: STABLE -> RUN directly, and ddr_calib_done is ignored.
//
// Parameters:
//   LOCK_STABLE_CYCLES  cycles pll_locked must stay high before release (2..2^20)
//   DEBOUNCE_CYCLES     consecutive stable cycles before a button change is taken (2..2^24)
//
// Ports:
//   clock            free-running board reference clock (only clock)
//   reset            synchronous, active-high reset
//   pll_locked       MMCM lock, asynchronous
//   button           reset push-button, active high, asynchronous
//   ddr_calib_done   DDR calibration complete, asynchronous
//   areset           registered system reset, low only while state == RUN
//   state            current FSM state (0 WAIT_LOCK, 1 STABLE, 2 WAIT_CALIB, 3 RUN)
//   lock_loss_count  saturating count of lock losses seen while in RUN

module zcu104_areset_gen #(
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned DEBOUNCE_CYCLES    = 65536
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic       button,
    input  logic       ddr_calib_done,
    output logic       areset,
    output logic [1:0] state,
    output logic [7:0] lock_loss_count
);

    localparam int unsigned LockW = $clog2(LOCK_STABLE_CYCLES);
    localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES);

    localparam logic [LockW-1:0] StableLast = LockW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [DbW-1:0]   DbLast     = DbW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StWaitLock  = 2'd0,
        StStable    = 2'd1,
        StWaitCalib = 2'd2,
        StRun       = 2'd3
    } state_e;

    // Power-up values keep areset asserted before the first reset is applied.
    state_e           state_q  = StWaitLock;
    state_e           state_d;
    logic             areset_q = 1'b1;
    logic [LockW-1:0] stable_cnt_q;
    logic [7:0]       lock_loss_q;

    logic [1:0]       locked_sync_q;
    logic [1:0]       button_sync_q;
    logic             locked_s;
    logic             button_s;

    logic [DbW-1:0]   db_cnt_q;
    logic             button_db_q;

    logic             calib_ok;
    logic             abort;

    // ---------------------------------------------------------------------
    // Input synchronizers
    // ---------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            locked_sync_q <= '0;
            button_sync_q <= '0;
        end else begin
            locked_sync_q <= {locked_sync_q[0], pll_locked};
            button_sync_q <= {button_sync_q[0], button};
        end
    end

    assign locked_s = locked_sync_q[1];
    assign button_s = button_sync_q[1];

`ifdef DDR_CALIB_GATE_EN
    logic [1:0] calib_sync_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            calib_sync_q <= '0;
        end else begin
            calib_sync_q <= {calib_sync_q[0], ddr_calib_done};
        end
    end

    assign calib_ok = calib_sync_q[1];
`else
    // Calibration gating is compiled out; the port is kept for pin compatibility.
    logic unused_calib;
    assign unused_calib = ddr_calib_done;
    assign calib_ok     = 1'b1;
`endif

    // ---------------------------------------------------------------------
    // Button debounce: accept a new level after DEBOUNCE_CYCLES
    // consecutive mismatching edges; any match restarts the count.
    // ---------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            db_cnt_q    <= '0;
            button_db_q <= 1'b0;
        end else if (button_s != button_db_q) begin
            if (db_cnt_q == DbLast) begin
                button_db_q <= button_s;
                db_cnt_q    <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + DbW'(1);
            end
        end else begin
            db_cnt_q <= '0;
        end
    end

    // ---------------------------------------------------------------------
    // Sequencing FSM
    // ---------------------------------------------------------------------
    assign abort = !locked_s || button_db_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StWaitLock: begin
                if (locked_s && !button_db_q) state_d = StStable;
            end
            StStable: begin
                if (abort) begin
                    state_d = StWaitLock;
                end else if (stable_cnt_q == StableLast) begin
`ifdef DDR_CALIB_GATE_EN
                    state_d = StWaitCalib;
`else
                    state_d = StRun;
`endif
                end
            end
            StWaitCalib: begin
                if (abort)         state_d = StWaitLock;
                else if (calib_ok) state_d = StRun;
            end
            StRun: begin
                if (abort) state_d = StWaitLock;
            end
            default: state_d = StWaitLock;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StWaitLock;
            areset_q     <= 1'b1;
            stable_cnt_q <= '0;
            lock_loss_q  <= '0;
        end else begin
            state_q  <= state_d;
            // Computed from the next state so areset rises on the same edge RUN is left.
            areset_q <= (state_d != StRun);

            // The count only advances while staying in STABLE, so it never passes StableLast.
            if (state_q == StStable && state_d == StStable) begin
                stable_cnt_q <= stable_cnt_q + LockW'(1);
            end else begin
                stable_cnt_q <= '0;
            end

            // Button-only exits from RUN are not lock losses.
            if (state_q == StRun && state_d == StWaitLock && !locked_s &&
                lock_loss_q != 8'hFF) begin
                lock_loss_q <= lock_loss_q + 8'd1;
            end
        end
    end

    assign areset          = areset_q;
    assign state           = state_q;
    assign lock_loss_count = lock_loss_q;

endmodule
